// File: rtl/fifo_pkg.sv
// Shared types and helpers for the programmable-threshold FIFO.
package fifo_pkg;

    // Read-side presentation: first-word-fall-through or registered output stage.
    typedef enum logic {
        FWFT = 1'b0,
        REG  = 1'b1
    } out_mode_e;

    // Number of storage entries for a given address width.
    function automatic int fifo_depth(input int asize);
        return 1 << asize;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write, combinational read.
// Contents are intentionally not reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DSIZE = 16,
    parameter int ASIZE = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);

    localparam int DEPTH = fifo_depth(ASIZE);

    logic [DSIZE-1:0] mem [DEPTH];

    // Write port: one entry per cycle when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_prog.sv
// Synchronous FIFO with programmable almost-full / almost-empty thresholds,
// selectable FWFT or registered read output, and synchronous flush.
// Optional feature: define FIFO_PROG_ERR_EN to add the sticky ovf_o port.
module fifo_prog
    import fifo_pkg::*;
#(
    parameter int DSIZE   = 16,
    parameter int ASIZE   = 4,
    parameter int OUT_REG = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             wr_valid_i,
    input  logic [DSIZE-1:0] wr_data_i,
    output logic             wr_ready_o,
    output logic             rd_valid_o,
    output logic [DSIZE-1:0] rd_data_o,
    input  logic             rd_ready_i,
    input  logic [ASIZE:0]   af_thresh_i,
    input  logic [ASIZE:0]   ae_thresh_i,
    output logic             almost_full_o,
    output logic             almost_empty_o,
    output logic [ASIZE:0]   level_o
`ifdef FIFO_PROG_ERR_EN
    ,
    output logic             ovf_o
`endif
);

    localparam int             DEPTH    = fifo_depth(ASIZE);
    localparam out_mode_e      MODE     = (OUT_REG != 0) ? REG : FWFT;
    localparam logic [ASIZE:0] FULL_LVL = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] LVL_ONE  = (ASIZE+1)'(1);
    localparam logic [ASIZE-1:0] PTR_ONE = ASIZE'(1);

    logic [ASIZE-1:0] wptr;
    logic [ASIZE-1:0] rptr;
    logic [ASIZE:0]   level;
    logic             push;
    logic             pop;
    logic             rd_adv;      // advance read pointer (memory entry consumed)
    logic [DSIZE-1:0] mem_rdata;

    // Level counts everything held, including an occupied output stage,
    // so wr_ready depends on flops only and never on rd_ready_i.
    assign wr_ready_o = (level < FULL_LVL);
    assign push       = wr_valid_i && wr_ready_o;
    assign pop        = rd_valid_o && rd_ready_i;
    assign level_o    = level;

    assign almost_full_o  = (level >= af_thresh_i);
    assign almost_empty_o = (level <= ae_thresh_i);

    fifo_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .clk   (clk),
        .we    (push && !flush_i),
        .waddr (wptr),
        .wdata (wr_data_i),
        .raddr (rptr),
        .rdata (mem_rdata)
    );

    // Pointer update; flush wins over any same-cycle push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push)   wptr <= wptr + PTR_ONE;
            if (rd_adv) rptr <= rptr + PTR_ONE;
        end
    end

    // Occupancy: +1 push only, -1 pop only, unchanged when both or neither.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= '0;
        end else if (flush_i) begin
            level <= '0;
        end else begin
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    generate
        if (MODE == FWFT) begin : g_fwft
            // Head of the memory is presented directly; data forced to zero
            // when empty so reset/flush leave a clean bus.
            assign rd_valid_o = (level != '0);
            assign rd_data_o  = rd_valid_o ? mem_rdata : '0;
            assign rd_adv     = pop;
        end else begin : g_reg
            logic             out_vld;
            logic [DSIZE-1:0] out_data;
            logic [ASIZE:0]   mem_cnt;
            logic             load;

            // Entries still in memory, i.e. not yet moved to the output stage.
            assign mem_cnt = level - {{ASIZE{1'b0}}, out_vld};
            // Refill the stage whenever it is empty or being drained this
            // cycle; this keeps back-to-back pops bubble-free.
            assign load    = (mem_cnt != '0) && (!out_vld || pop);
            assign rd_adv  = load;

            // Registered output stage.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_vld  <= 1'b0;
                    out_data <= '0;
                end else if (flush_i) begin
                    out_vld  <= 1'b0;
                end else if (load) begin
                    out_vld  <= 1'b1;
                    out_data <= mem_rdata;
                end else if (pop) begin
                    out_vld  <= 1'b0;
                end
            end

            assign rd_valid_o = out_vld;
            assign rd_data_o  = out_data;
        end
    endgenerate

`ifdef FIFO_PROG_ERR_EN
    // Sticky overflow: a write attempted while full; cleared by flush or reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_o <= 1'b0;
        end else if (flush_i) begin
            ovf_o <= 1'b0;
        end else if (wr_valid_i && !wr_ready_o) begin
            ovf_o <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_prog.sv
// Scoreboard bench for fifo_prog: DSIZE=8, ASIZE=3, one instance per
// OUT_REG value, exercised one at a time through a shared stimulus.
module tb_fifo_prog;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       rd_ready;
    logic [3:0] af_th;
    logic [3:0] ae_th;
    logic       sel;

    logic       f_wr_ready, r_wr_ready, wr_ready;
    logic       f_rd_valid, r_rd_valid, rd_valid;
    logic [7:0] f_rd_data,  r_rd_data,  rd_data;
    logic       f_af, r_af, af;
    logic       f_ae, r_ae, ae;
    logic [3:0] f_level, r_level, level;
`ifdef FIFO_PROG_ERR_EN
    logic       f_ovf, r_ovf, ovf;
    assign ovf = sel ? r_ovf : f_ovf;
`endif

    assign wr_ready = sel ? r_wr_ready : f_wr_ready;
    assign rd_valid = sel ? r_rd_valid : f_rd_valid;
    assign rd_data  = sel ? r_rd_data  : f_rd_data;
    assign af       = sel ? r_af       : f_af;
    assign ae       = sel ? r_ae       : f_ae;
    assign level    = sel ? r_level    : f_level;

    fifo_prog #(.DSIZE(8), .ASIZE(3), .OUT_REG(0)) u_fwft (
        .clk(clk), .rst(rst), .flush_i(flush),
        .wr_valid_i(wr_valid), .wr_data_i(wr_data), .wr_ready_o(f_wr_ready),
        .rd_valid_o(f_rd_valid), .rd_data_o(f_rd_data), .rd_ready_i(rd_ready),
        .af_thresh_i(af_th), .ae_thresh_i(ae_th),
        .almost_full_o(f_af), .almost_empty_o(f_ae), .level_o(f_level)
`ifdef FIFO_PROG_ERR_EN
        , .ovf_o(f_ovf)
`endif
    );

    fifo_prog #(.DSIZE(8), .ASIZE(3), .OUT_REG(1)) u_reg (
        .clk(clk), .rst(rst), .flush_i(flush),
        .wr_valid_i(wr_valid), .wr_data_i(wr_data), .wr_ready_o(r_wr_ready),
        .rd_valid_o(r_rd_valid), .rd_data_o(r_rd_data), .rd_ready_i(rd_ready),
        .af_thresh_i(af_th), .ae_thresh_i(ae_th),
        .almost_full_o(r_af), .almost_empty_o(r_ae), .level_o(r_level)
`ifdef FIFO_PROG_ERR_EN
        , .ovf_o(r_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         npop   = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL mode%0d %s: got 0x%0h expected 0x%0h", sel, name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_level"},    level,    0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_rd_data"},  rd_data,  0);
        chk({tag, "_wr_ready"}, wr_ready, 1);
        chk({tag, "_ae"},       ae,       1);
`ifdef FIFO_PROG_ERR_EN
        chk({tag, "_ovf"},      ovf,      0);
`endif
    endtask

    task automatic wait_empty(input int max, input string tag);
        for (int k = 0; k < max; k++) begin
            if (level == 0) break;
            step();
        end
        chk(tag, level, 0);
    endtask

    task automatic wait_valid(input int max, input string tag);
        for (int k = 0; k < max; k++) begin
            if (rd_valid) break;
            step();
        end
        chk(tag, rd_valid, 1);
    endtask

    task automatic push_n(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(base + i);
            step();
        end
        wr_valid = 1'b0;
    endtask

    // Monitor: records accepted writes, compares every accepted read against
    // the oldest outstanding write. Reset and flush discard everything held.
    initial begin
        forever begin
            @(negedge clk);
            if (rst || flush) begin
                exp_q.delete();
            end else begin
                if (rd_valid && rd_ready) begin
                    npop++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL mode%0d unexpected_pop: got 0x%0h expected no data", sel, rd_data);
                    end else begin
                        chk("rd_data_order", rd_data, exp_q.pop_front());
                    end
                end
                if (wr_valid && wr_ready) exp_q.push_back(wr_data);
            end
        end
    end

    task automatic run_mode();
        int         p0;
        logic [5:0] af_tab;
        logic [5:0] ae_tab;

        // Reset state
        rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        af_th = 4'd6; ae_th = 4'd1;
        step(); step();
        chk_reset("reset");
        rst = 1'b0;
        step();

        // Fill to full, then drain in order
        push_n(8, 'h10);
        chk("full_wr_ready", wr_ready, 0);
        chk("full_level",    level,    8);
        chk("full_af",       af,       1);
        chk("full_ae",       ae,       0);
        p0 = npop;
        rd_ready = 1'b1;
        wait_empty(30, "drain_level");
        rd_ready = 1'b0;
        chk("drain_count", npop - p0, 8);
        chk("drain_queue", exp_q.size(), 0);

        // Threshold flags: af rises at level 6, ae falls at level 2
        af_tab = 6'b100000;
        ae_tab = 6'b000001;
        chk("thr_af_l0", af, 0);
        chk("thr_ae_l0", ae, 1);
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1'b1;
            wr_data  = 8'(32'h30 + i);
            step();
            chk("thr_level", level, i + 1);
            chk("thr_af",    af,    af_tab[i]);
            chk("thr_ae",    ae,    ae_tab[i]);
        end
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        wait_empty(30, "thr_drain");
        rd_ready = 1'b0;

        // Streaming at level 3 across pointer wrap, no bubbles
        push_n(3, 'h20);
        step(); step();
        chk("stream_start_level", level, 3);
        chk("stream_start_valid", rd_valid, 1);
        p0 = npop;
        for (int i = 0; i < 20; i++) begin
            wr_valid = 1'b1;
            rd_ready = 1'b1;
            wr_data  = 8'(32'h23 + i);
            step();
            chk("stream_level", level, 3);
            chk("stream_no_bubble", rd_valid, 1);
        end
        wr_valid = 1'b0;
        chk("stream_pops", npop - p0, 20);
        wait_empty(30, "stream_drain");
        rd_ready = 1'b0;
        chk("stream_queue", exp_q.size(), 0);

        // Push at full with a simultaneous pop is rejected
        push_n(8, 'h40);
        wr_valid = 1'b1; wr_data = 8'h99; rd_ready = 1'b1;
        step();
        wr_valid = 1'b0; rd_ready = 1'b0;
        chk("ovf_level", level, 7);
        chk("ovf_wr_ready", wr_ready, 1);
`ifdef FIFO_PROG_ERR_EN
        chk("ovf_set", ovf, 1);
        step();
        chk("ovf_sticky", ovf, 1);
`endif
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("ovf_flush_level", level, 0);
        chk("ovf_flush_valid", rd_valid, 0);
`ifdef FIFO_PROG_ERR_EN
        chk("ovf_cleared", ovf, 0);
`endif

        // Flush with a same-cycle push at level 5
        push_n(5, 'h50);
        chk("flush_pre_level", level, 5);
        flush = 1'b1; wr_valid = 1'b1; wr_data = 8'hEE; rd_ready = 1'b1;
        step();
        flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        chk("flush_level", level, 0);
        chk("flush_valid", rd_valid, 0);
        push_n(1, 'h60);
        wait_valid(5, "flush_next_valid");
        chk("flush_next_data", rd_data, 'h60);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        chk("flush_next_level", level, 0);

        // Asynchronous reset mid-stream at level 4
        push_n(4, 'h70);
        chk("rst_pre_level", level, 4);
        rst = 1'b1;
        #1;
        chk_reset("rst_async");
        step();
        rst = 1'b0;
        step();
        push_n(1, 'hAA);
        wait_valid(5, "rst_next_valid");
        chk("rst_next_data", rd_data, 'hAA);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        chk("rst_next_level", level, 0);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wr_valid = 1'b0; wr_data = '0;
        rd_ready = 1'b0; af_th = 4'd6; ae_th = 4'd1; sel = 1'b0;
        for (int m = 0; m < 2; m++) begin
            sel = m[0];
            run_mode();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fifo_prog.md
FIFO_PROG -- requirements
Module: fifo_prog

Interface
REQ-001 SHALL have parameter DSIZE, default 16, data width in bits.
REQ-002 SHALL have parameter ASIZE, default 4, address width; DEPTH = 2**ASIZE entries; ASIZE >= 2.
REQ-003 SHALL have parameter OUT_REG, default 0; 0 = first-word-fall-through read, 1 = registered output stage.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port flush_i  input  1  synchronous clear.
REQ-007 SHALL have port wr_valid_i  input  1  write request.
REQ-008 SHALL have port wr_data_i  input  DSIZE  write data.
REQ-009 SHALL have port wr_ready_o  output  1  FIFO can accept a write.
REQ-010 SHALL have port rd_valid_o  output  1  rd_data_o holds the oldest entry.
REQ-011 SHALL have port rd_data_o  output  DSIZE  read data.
REQ-012 SHALL have port rd_ready_i  input  1  consumer accepts rd_data_o.
REQ-013 SHALL have port af_thresh_i  input  ASIZE+1  almost-full threshold.
REQ-014 SHALL have port ae_thresh_i  input  ASIZE+1  almost-empty threshold.
REQ-015 SHALL have ports almost_full_o and almost_empty_o  output  1  each  threshold flags.
REQ-016 SHALL have port level_o  output  ASIZE+1  entries held, 0..DEPTH.
REQ-017 SHALL have port ovf_o  output  1  sticky overflow flag; present only under FIFO_PROG_ERR_EN.

Function
REQ-018 SHALL perform a push when wr_valid_i && wr_ready_o, and a pop when rd_valid_o && rd_ready_i.
REQ-019 SHALL drive wr_ready_o = (level_o < DEPTH) from registered state only; no combinational path from rd_ready_i to wr_ready_o.
REQ-020 SHALL count in level_o every entry held, including any entry in the OUT_REG stage; total capacity is DEPTH in both modes.
REQ-021 SHALL update level_o by +1 on push-only, -1 on pop-only, and 0 on simultaneous push and pop.
REQ-022 SHALL, with OUT_REG=0 and the FIFO empty, assert rd_valid_o in the cycle after the push edge, with rd_data_o valid in that same cycle.
REQ-023 SHALL, with OUT_REG=1, drive rd_data_o and rd_valid_o from flops, adding exactly one cycle of first-data latency; thereafter it SHALL sustain one pop per cycle with no bubbles.
REQ-024 SHALL hold rd_data_o and rd_valid_o stable while rd_valid_o && !rd_ready_i.
REQ-025 SHALL wrap ASIZE-bit read and write pointers modulo DEPTH with no lost or duplicated entries.
REQ-026 SHALL compute almost_full_o = (level_o >= af_thresh_i) and almost_empty_o = (level_o <= ae_thresh_i), both unsigned and combinational from level_o.
REQ-027 SHALL reject a push when full, even if a pop occurs in the same cycle.
REQ-028 SHALL, on flush_i, set level_o, both pointers, rd_valid_o and ovf_o to 0 at the next edge.
REQ-029 SHALL, on flush_i, ignore any push or pop in the same cycle; flush_i has priority.

Reset
REQ-030 SHALL, while rst is high, asynchronously force level_o=0, pointers=0, rd_valid_o=0, rd_data_o=0, wr_ready_o=1, almost_empty_o=1 and ovf_o=0.
REQ-031 SHALL not reset memory contents.
REQ-032 SHALL, when rst asserts mid-transfer, discard all held data; the first push after rst deasserts is the first entry read.

Configuration
REQ-033 SHALL, with macro FIFO_PROG_ERR_EN defined, set ovf_o at the edge where wr_valid_i && !wr_ready_o; it stays set until flush_i or rst.
REQ-034 SHALL, without FIFO_PROG_ERR_EN, omit the ovf_o port and its logic; all other behaviour is identical.

Structure
REQ-035 SHALL place shared items in package fifo_pkg: the out_mode_e typedef (FWFT, REG) and a function computing DEPTH from ASIZE.
REQ-036 SHALL instantiate one sub-module, fifo_mem: a simple dual-port DEPTH x DSIZE array with a synchronous write port and a combinational read port.

Verification (DSIZE=8, ASIZE=3, both OUT_REG values)
REQ-037 SHALL check: push 8 words 0x10..0x17 with rd_ready_i=0 -> wr_ready_o=0 and level_o=8; then pop all -> data read in order 0x10..0x17 and level_o=0.
REQ-038 SHALL check: af_thresh_i=6, ae_thresh_i=1, push 6 words -> almost_full_o rises at level 6 and almost_empty_o falls at level 2.
REQ-039 SHALL check: continuous push+pop for 20 cycles starting at level 3 -> level_o stays 3, data is in order across pointer wrap, and there are no bubbles.
REQ-040 SHALL check: at full, push with rd_ready_i=1 -> push rejected, level_o=7; with FIFO_PROG_ERR_EN defined, ovf_o=1 until flush_i.
REQ-041 SHALL check: flush_i with push in the same cycle at level 5 -> level_o=0 and rd_valid_o=0 next cycle, and the pushed word is discarded.
REQ-042 SHALL check: rst pulse mid-stream at level 4 -> outputs match REQ-030 immediately; the next push 0xAA is the first data read.
